// File: rtl/if_id_queue.sv
// IF/ID pipeline stage with a DEPTH-entry instruction/PC FIFO ahead of the
// registered decode-side output, so fetch can keep running while decode stalls.
module if_id_queue #(
  parameter int unsigned          INSTR_W  = 32,
  parameter int unsigned          PC_W     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [INSTR_W-1:0]   NOP_CODE = INSTR_W'(32'hF0000000)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INSTR_W-1:0]           Instruction_code,
  input  logic [PC_W-1:0]              PC,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         stall,
  input  logic                         jump,
  output logic [INSTR_W-1:0]           Instruction_code_IfId,
  output logic [PC_W-1:0]              PC_if_id,
  output logic                         out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [INSTR_W-1:0] instr_q,  instr_d;
  logic [PC_W-1:0]    pc_q,     pc_d;
  logic               valid_q,  valid_d;

  logic accept_c;
  logic push_c;
  logic pop_c;
  logic empty_c;

  // Readiness depends only on registered occupancy; a full queue never
  // passes input straight through even if decode drains this cycle.
  assign in_ready = reset & (count_q < CNT_W'(DEPTH));
  assign empty_c  = (count_q == '0);
  assign accept_c = in_valid & in_ready;
  assign pop_c    = ~jump & ~stall & ~empty_c;
  // An empty, advancing queue bypasses input directly to the output stage.
  assign push_c   = ~jump & accept_c & (stall | ~empty_c);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    valid_d  = valid_q;

    if (jump) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      instr_d  = NOP_CODE;
      pc_d     = PC;
      valid_d  = 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      if (!stall) begin
        if (!empty_c) begin
          instr_d = instr_mem_q[rd_ptr_q];
          pc_d    = pc_mem_q[rd_ptr_q];
          valid_d = 1'b1;
        end else if (accept_c) begin
          instr_d = Instruction_code;
          pc_d    = PC;
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_CODE;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      instr_q  <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[wr_ptr_q] <= Instruction_code;
      pc_mem_q[wr_ptr_q]    <= PC;
    end
  end

  assign Instruction_code_IfId = instr_q;
  assign PC_if_id              = pc_q;
  assign out_valid             = valid_q;
  assign count                 = count_q;

endmodule
